// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/redirect control for a 5-stage pipeline, with perf counters and a sticky memory-timeout flag
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rR1,
  input  logic [4:0]       id_rR2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [4:0]       ex_wR,
  input  logic             ex_rf_we,
  input  logic             ex_is_load,
  input  logic             ex_br_taken,
  input  logic             mem_busy,
  input  logic             perf_clr,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             mem_wb_stall,
  output logic             redirect_valid,
  output logic             err_timeout,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_flush,
  output logic [CNT_W-1:0] cnt_freeze
);
  localparam logic [1:0] RUN = 2'd0, FREEZE = 2'd1, ERR = 2'd2;
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [1:0] state_q, state_d;
  logic [WW-1:0] wait_q, wait_d, wait_inc;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d, freeze_q, freeze_d;
  logic lu, fz, rd, ld;
  assign lu = ex_is_load & ex_rf_we & (ex_wR != 5'd0) &
              ((id_use1 & (id_rR1 == ex_wR)) | (id_use2 & (id_rR2 == ex_wR)));
  assign fz = mem_busy;
  assign rd = !mem_busy & ex_br_taken;
  assign ld = !mem_busy & !ex_br_taken & lu;
  assign pc_stall = fz | ld;
  assign if_id_stall = fz | ld;
  assign if_id_flush = rd;
  assign id_ex_stall = fz;
  assign id_ex_flush = rd | ld;
  assign ex_mem_stall = fz;
  assign mem_wb_stall = fz;
  assign redirect_valid = rd;
  assign err_timeout = state_q == ERR;
  assign cnt_stall = stall_q;
  assign cnt_flush = flush_q;
  assign cnt_freeze = freeze_q;
  assign wait_inc = wait_q + WW'(1);
  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c, input logic inc);
    return (inc && c != '1) ? c + CNT_W'(1) : c;
  endfunction
  always_comb begin
    state_d = state_q == ERR ? ERR :
              !mem_busy ? RUN :
              (state_q == FREEZE && wait_inc == WW'(TIMEOUT)) ? ERR : FREEZE;
    wait_d = state_q == ERR ? wait_q : !mem_busy ? '0 : wait_inc;
    stall_d = perf_clr ? '0 : sat(stall_q, ld);
    flush_d = perf_clr ? '0 : sat(flush_q, rd);
    freeze_d = perf_clr ? '0 : sat(freeze_q, fz);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      wait_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
      freeze_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      freeze_q <= freeze_d;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  logic clk = 0, rst = 0;
  logic [4:0] id_rR1, id_rR2, ex_wR;
  logic id_use1, id_use2, ex_rf_we, ex_is_load, ex_br_taken, mem_busy, perf_clr;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_stall, redirect_valid, err_timeout;
  logic [1:0] cnt_stall, cnt_flush, cnt_freeze;
  logic [7:0] ctrl;
  int cmp = 0, errs = 0;
  localparam logic [7:0] NONE = 8'b00000000, FZ = 8'b11010110, RD = 8'b00101001, LU = 8'b11001000;
  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .id_rR1(id_rR1), .id_rR2(id_rR2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_wR(ex_wR), .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
    .mem_busy(mem_busy), .perf_clr(perf_clr), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .if_id_flush(if_id_flush), .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .mem_wb_stall(mem_wb_stall), .redirect_valid(redirect_valid),
    .err_timeout(err_timeout), .cnt_stall(cnt_stall), .cnt_flush(cnt_flush), .cnt_freeze(cnt_freeze));
  assign ctrl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_stall, redirect_valid};
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    {id_rR1, id_rR2, ex_wR} = '0;
    {id_use1, id_use2, ex_rf_we, ex_is_load, ex_br_taken, mem_busy, perf_clr} = '0;
  endtask
  task automatic hazard();
    ex_is_load = 1; ex_rf_we = 1; ex_wR = 5; id_rR2 = 5; id_use2 = 1;
  endtask
  task automatic do_reset();
    idle();
    rst = 0;
    tick();
    rst = 1;
  endtask
  task automatic test_reset();
    idle();
    mem_busy = 1;
    rst = 1;
    tick();
    tick();
    rst = 0;
    tick();
    tick();
    mem_busy = 0;
    rst = 1;
    #1;
    cmp++; if (ctrl !== NONE) begin errs++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, NONE); end
    cmp++; if (cnt_freeze !== 2'd0) begin errs++; $display("FAIL reset_cnt_freeze got=%0d exp=0", cnt_freeze); end
    cmp++; if (err_timeout !== 1'b0) begin errs++; $display("FAIL reset_err got=%b exp=0", err_timeout); end
    tick();
    cmp++; if ({cnt_stall, cnt_flush, cnt_freeze} !== 6'd0) begin errs++; $display("FAIL reset_cnts got=%b exp=0", {cnt_stall, cnt_flush, cnt_freeze}); end
  endtask
  task automatic test_load_use();
    do_reset();
    hazard();
    #1;
    cmp++; if (ctrl !== LU) begin errs++; $display("FAIL lu_ctrl got=%b exp=%b", ctrl, LU); end
    tick();
    cmp++; if (cnt_stall !== 2'd1) begin errs++; $display("FAIL lu_cnt got=%0d exp=1", cnt_stall); end
    ex_wR = 0; id_rR2 = 0;
    #1;
    cmp++; if (ctrl !== NONE) begin errs++; $display("FAIL lu_r0 got=%b exp=%b", ctrl, NONE); end
    ex_wR = 7; id_rR1 = 7; id_rR2 = 3; id_use1 = 0;
    #1;
    cmp++; if (ctrl !== NONE) begin errs++; $display("FAIL lu_nouse got=%b exp=%b", ctrl, NONE); end
    id_use1 = 1; id_use2 = 0;
    #1;
    cmp++; if (ctrl !== LU) begin errs++; $display("FAIL lu_rr1 got=%b exp=%b", ctrl, LU); end
    ex_is_load = 0;
    #1;
    cmp++; if (ctrl !== NONE) begin errs++; $display("FAIL lu_noload got=%b exp=%b", ctrl, NONE); end
    ex_is_load = 1; ex_rf_we = 0;
    #1;
    cmp++; if (ctrl !== NONE) begin errs++; $display("FAIL lu_nowe got=%b exp=%b", ctrl, NONE); end
    tick();
    cmp++; if (cnt_stall !== 2'd1) begin errs++; $display("FAIL lu_cnt_hold got=%0d exp=1", cnt_stall); end
  endtask
  task automatic test_redirect_lu();
    idle();
    hazard();
    ex_br_taken = 1;
    #1;
    cmp++; if (ctrl !== RD) begin errs++; $display("FAIL rd_ctrl got=%b exp=%b", ctrl, RD); end
    tick();
    cmp++; if (cnt_flush !== 2'd1) begin errs++; $display("FAIL rd_cnt_flush got=%0d exp=1", cnt_flush); end
    cmp++; if (cnt_stall !== 2'd1) begin errs++; $display("FAIL rd_cnt_stall got=%0d exp=1", cnt_stall); end
  endtask
  task automatic test_freeze_redirect();
    do_reset();
    mem_busy = 1; ex_br_taken = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      cmp++; if (ctrl !== FZ) begin errs++; $display("FAIL fz_ctrl[%0d] got=%b exp=%b", i, ctrl, FZ); end
      tick();
    end
    cmp++; if (cnt_freeze !== 2'd3) begin errs++; $display("FAIL fz_cnt got=%0d exp=3", cnt_freeze); end
    cmp++; if (err_timeout !== 1'b0) begin errs++; $display("FAIL fz_err got=%b exp=0", err_timeout); end
    mem_busy = 0;
    #1;
    cmp++; if (ctrl !== RD) begin errs++; $display("FAIL fz_rd got=%b exp=%b", ctrl, RD); end
    tick();
    cmp++; if (cnt_flush !== 2'd1) begin errs++; $display("FAIL fz_rd_cnt got=%0d exp=1", cnt_flush); end
    ex_br_taken = 0;
    #1;
    cmp++; if (ctrl !== NONE) begin errs++; $display("FAIL fz_after got=%b exp=%b", ctrl, NONE); end
    mem_busy = 1;
    tick();
    tick();
    tick();
    mem_busy = 0;
    tick();
    cmp++; if (err_timeout !== 1'b0) begin errs++; $display("FAIL fz_wait_clear got=%b exp=0", err_timeout); end
  endtask
  task automatic test_timeout();
    do_reset();
    mem_busy = 1;
    for (int i = 0; i < 3; i++) tick();
    cmp++; if (err_timeout !== 1'b0) begin errs++; $display("FAIL to_early got=%b exp=0", err_timeout); end
    tick();
    cmp++; if (err_timeout !== 1'b1) begin errs++; $display("FAIL to_set got=%b exp=1", err_timeout); end
    cmp++; if (cnt_freeze !== 2'd3) begin errs++; $display("FAIL to_cnt_sat got=%0d exp=3", cnt_freeze); end
    mem_busy = 0;
    hazard();
    #1;
    cmp++; if (ctrl !== LU) begin errs++; $display("FAIL to_err_lu got=%b exp=%b", ctrl, LU); end
    tick();
    tick();
    cmp++; if (err_timeout !== 1'b1) begin errs++; $display("FAIL to_sticky got=%b exp=1", err_timeout); end
    idle();
    perf_clr = 1;
    tick();
    perf_clr = 0;
    cmp++; if (err_timeout !== 1'b1) begin errs++; $display("FAIL to_clr_sticky got=%b exp=1", err_timeout); end
    rst = 0;
    tick();
    rst = 1;
    cmp++; if (err_timeout !== 1'b0) begin errs++; $display("FAIL to_rst got=%b exp=0", err_timeout); end
  endtask
  task automatic test_saturation();
    do_reset();
    hazard();
    for (int i = 0; i < 5; i++) tick();
    cmp++; if (cnt_stall !== 2'd3) begin errs++; $display("FAIL sat_cnt got=%0d exp=3", cnt_stall); end
    perf_clr = 1;
    tick();
    cmp++; if (cnt_stall !== 2'd0) begin errs++; $display("FAIL sat_clr got=%0d exp=0", cnt_stall); end
    perf_clr = 0;
    tick();
    cmp++; if (cnt_stall !== 2'd1) begin errs++; $display("FAIL sat_restart got=%0d exp=1", cnt_stall); end
    perf_clr = 1; rst = 0;
    tick();
    rst = 1; perf_clr = 0;
    cmp++; if (cnt_stall !== 2'd0) begin errs++; $display("FAIL sat_rst got=%0d exp=0", cnt_stall); end
  endtask
  task automatic test_back_to_back();
    do_reset();
    hazard();
    #1;
    cmp++; if (ctrl !== LU) begin errs++; $display("FAIL b2b_lu got=%b exp=%b", ctrl, LU); end
    tick();
    ex_br_taken = 1;
    #1;
    cmp++; if (ctrl !== RD) begin errs++; $display("FAIL b2b_rd got=%b exp=%b", ctrl, RD); end
    tick();
    mem_busy = 1;
    #1;
    cmp++; if (ctrl !== FZ) begin errs++; $display("FAIL b2b_fz got=%b exp=%b", ctrl, FZ); end
    tick();
    cmp++; if ({cnt_stall, cnt_flush, cnt_freeze} !== 6'b010101) begin errs++; $display("FAIL b2b_cnts got=%b exp=010101", {cnt_stall, cnt_flush, cnt_freeze}); end
    rst = 0;
    tick();
    rst = 1;
    cmp++; if ({cnt_stall, cnt_flush, cnt_freeze} !== 6'd0) begin errs++; $display("FAIL b2b_rst_fz got=%b exp=0", {cnt_stall, cnt_flush, cnt_freeze}); end
    mem_busy = 0; ex_br_taken = 0;
    tick();
    cmp++; if (err_timeout !== 1'b0) begin errs++; $display("FAIL b2b_err got=%b exp=0", err_timeout); end
  endtask
  initial begin
    idle();
    test_reset();
    test_load_use();
    test_redirect_lu();
    test_freeze_redirect();
    test_timeout();
    test_saturation();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
